// File: rtl/cen_controller_pkg.sv
// Shared defaults and FSM state type for the four-channel frame-averaging controller.
package cen_controller_pkg;

  localparam int N_SAMPLES_DEF = 128;
  localparam int LOG2_N_DEF    = 7;
  localparam int DW_DEF        = 26;
  localparam int AW_DEF        = 40;
  localparam int N_CH          = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIVIDE,
    ST_WAIT,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/cen_controller_divider_unit.sv
// Shift-based divider: on enable, registers sum_k >> LOG2_N truncated to DW bits for all channels.
module cen_controller_divider_unit
  import cen_controller_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_CH-1:0][AW-1:0]    sum_in,
  output logic [N_CH-1:0][DW-1:0]    mean_out
);

  logic [N_CH-1:0][DW-1:0] mean_d;
  logic [N_CH-1:0][DW-1:0] mean_q;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mean_d = mean_q;
    if (en) begin
      for (int k = 0; k < N_CH; k++) begin
        mean_d[k] = DW'(sum_in[k] >> LOG2_N);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_q <= '0;
    end else begin
      mean_q <= mean_d;
    end
  end

  assign mean_out = mean_q;

endmodule

// File: rtl/cen_controller.sv
// Frame controller: accumulates N_SAMPLES four-channel sample sets, divides by shift, and holds
// the per-channel means until the consumer accepts them.
module cen_controller
  import cen_controller_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int LOG2_N    = LOG2_N_DEF,
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  input  logic [DW-1:0] x4,
  output logic          mean_valid,
  input  logic          mean_ready,
  output logic [DW-1:0] mean1,
  output logic [DW-1:0] mean2,
  output logic [DW-1:0] mean3,
  output logic [DW-1:0] mean4,
  output logic          busy,
  output logic          done
);

  localparam int                CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_SAMPLES - 1);

  state_e state_q;
  logic   in_ready_q;
  logic   div_en_q;
  logic   mean_valid_q;
  logic   busy_q;

  logic [N_CH-1:0][AW-1:0] sum_d;
  logic [N_CH-1:0][AW-1:0] sum_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [N_CH-1:0][DW-1:0] x_arr;
  logic [N_CH-1:0][DW-1:0] mean_arr;

  logic accept;
  logic frame_start;
  logic last_accept;
  logic hold_hs;

  assign x_arr       = {x4, x3, x2, x1};
  assign accept      = in_ready_q & in_valid;
  assign frame_start = (state_q == ST_IDLE) & start;
  assign last_accept = accept & (cnt_q == CNT_LAST);
  assign hold_hs     = mean_valid_q & mean_ready;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (frame_start) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      for (int k = 0; k < N_CH; k++) begin
        sum_d[k] = sum_q[k] + AW'(x_arr[k]);
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: the sum registers are reset explicitly; an aborted frame must never leak into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // Control FSM; outputs are registered alongside the state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      div_en_q     <= 1'b0;
      mean_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (last_accept) begin
            state_q    <= ST_DIVIDE;
            in_ready_q <= 1'b0;
            div_en_q   <= 1'b1;
          end
        end
        ST_DIVIDE: begin
          state_q  <= ST_WAIT;
          div_en_q <= 1'b0;
        end
        ST_WAIT: begin
          state_q      <= ST_HOLD;
          mean_valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (mean_ready) begin
            state_q      <= ST_IDLE;
            mean_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          in_ready_q   <= 1'b0;
          div_en_q     <= 1'b0;
          mean_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  cen_controller_divider_unit #(
    .LOG2_N (LOG2_N),
    .DW     (DW),
    .AW     (AW)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (div_en_q),
    .sum_in   (sum_q),
    .mean_out (mean_arr)
  );

  assign in_ready   = in_ready_q;
  assign mean_valid = mean_valid_q;
  assign busy       = busy_q;
  assign done       = hold_hs;
  assign mean1      = mean_arr[0];
  assign mean2      = mean_arr[1];
  assign mean3      = mean_arr[2];
  assign mean4      = mean_arr[3];

endmodule

// File: tb/tb_cen_controller.sv
// Randomized self-checking bench for cen_controller against a frame-level averaging model.
module tb_cen_controller;
  import cen_controller_pkg::*;

  localparam int N    = 128;
  localparam int DW_T = 26;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [DW_T-1:0] x1, x2, x3, x4;
  logic            mean_valid;
  logic            mean_ready;
  logic [DW_T-1:0] mean1, mean2, mean3, mean4;
  logic            busy;
  logic            done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW_T-1:0] smp [N][4];
  longint          exp_mean [4];

  cen_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4),
    .mean_valid (mean_valid),
    .mean_ready (mean_ready),
    .mean1      (mean1),
    .mean2      (mean2),
    .mean3      (mean3),
    .mean4      (mean4),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW_T-1:0] mean_of(input int k);
    case (k)
      0:       return mean1;
      1:       return mean2;
      2:       return mean3;
      default: return mean4;
    endcase
  endfunction

  task automatic fill_const(input logic [DW_T-1:0] a, b, c, d);
    for (int i = 0; i < N; i++) begin
      smp[i][0] = a; smp[i][1] = b; smp[i][2] = c; smp[i][3] = d;
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) begin
      smp[i][0] = DW_T'(i);
      for (int k = 1; k < 4; k++) smp[i][k] = DW_T'($urandom);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) smp[i][k] = DW_T'($urandom);
  endtask

  // Mean of the frame as plain integer arithmetic over the stored sample table.
  task automatic compute_expected();
    for (int k = 0; k < 4; k++) begin
      longint s = 0;
      for (int i = 0; i < N; i++) s += longint'(smp[i][k]);
      exp_mean[k] = (s / N) & ((64'd1 << DW_T) - 1);
    end
  endtask

  task automatic drive_set(input bit v, input int idx);
    in_valid = v;
    x1 = v ? smp[idx][0] : DW_T'($urandom);
    x2 = v ? smp[idx][1] : DW_T'($urandom);
    x3 = v ? smp[idx][2] : DW_T'($urandom);
    x4 = v ? smp[idx][3] : DW_T'($urandom);
  endtask

  // gap_mode: 0 back-to-back, 1 one valid per three cycles, 2 random gaps.
  task automatic run_frame(input string name, input int gap_mode, input int hold_cycles,
                           input bit start_at_hs);
    int idx, cyc, lat;
    bit v, ready_err, stable_err;
    compute_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy_after_start"}, busy, 1);
    idx = 0; cyc = 0; ready_err = 0;
    while (idx < N && cyc < 4000) begin
      if (in_ready !== 1'b1) ready_err = 1;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      drive_set(v, idx);
      @(negedge clk);
      if (v) idx++;
      cyc++;
    end
    drive_set(1'b0, 0);
    check({name, ".accepts"}, idx, N);
    check({name, ".in_ready_during_accum"}, ready_err, 0);
    check({name, ".in_ready_after_last"}, in_ready, 0);
    lat = 1;
    while (mean_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, lat, 3);
    for (int k = 0; k < 4; k++) check($sformatf("%s.mean%0d", name, k + 1), mean_of(k), exp_mean[k]);
    stable_err = 0;
    for (int c = 0; c < hold_cycles; c++) begin
      mean_ready = 1'b0;
      start = (c == hold_cycles / 2);
      @(negedge clk);
      start = 1'b0;
      if (mean_valid !== 1'b1 || done !== 1'b0) stable_err = 1;
      for (int k = 0; k < 4; k++) if (mean_of(k) !== exp_mean[k]) stable_err = 1;
    end
    if (hold_cycles > 0) check({name, ".hold_stable"}, stable_err, 0);
    mean_ready = 1'b1;
    start = start_at_hs;
    #1;
    check({name, ".done_on_handshake"}, done, 1);
    @(negedge clk);
    mean_ready = 1'b0;
    start = 1'b0;
    check({name, ".done_single"}, done, 0);
    check({name, ".mean_valid_cleared"}, mean_valid, 0);
    check({name, ".busy_idle_gap"}, busy, 0);
    check({name, ".mean1_retained"}, mean1, exp_mean[0]);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".in_ready"}, in_ready, 0);
    check({name, ".mean_valid"}, mean_valid, 0);
    check({name, ".busy"}, busy, 0);
    check({name, ".done"}, done, 0);
    for (int k = 0; k < 4; k++) check($sformatf("%s.mean%0d", name, k + 1), mean_of(k), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mean_ready = 1'b0;
    drive_set(1'b0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill_const(26'd100, 26'd0, 26'h3FF_FFFF, 26'd7);
    run_frame("const", 0, 0, 1'b0);

    fill_ramp();
    run_frame("ramp", 0, 0, 1'b0);

    fill_const(26'd100, 26'd0, 26'h3FF_FFFF, 26'd7);
    run_frame("gapped", 1, 0, 1'b0);

    fill_rand();
    run_frame("backpressure", 1, 10, 1'b1);
    repeat (2) @(negedge clk);
    check("backpressure.start_at_hs_ignored", busy, 0);

    // Abort a frame after 50 accepts with values that would pollute the next mean.
    fill_const(26'd1000, 26'd2000, 26'd3000, 26'd4000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive_set(1'b1, i);
      @(negedge clk);
    end
    drive_set(1'b0, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_const(26'd5, 26'd5, 26'd5, 26'd5);
    run_frame("after_reset", 0, 0, 1'b0);

    fill_const(26'd11, 26'd22, 26'd33, 26'd44);
    run_frame("consec_a", 0, 0, 1'b0);
    fill_const(26'd900, 26'd800, 26'd700, 26'd600);
    run_frame("consec_b", 0, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_frame($sformatf("rand%0d", r), 2, int'($urandom_range(0, 5)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
